// File: rtl/stream_vect_packer_pkg.sv
// -----------------------------------------------------------------------------
// stream_vect_packer_pkg
// Shared definitions for the stream vector packer:
//   - lane_cntw()   : width of the lane counter for a given lane count
//   - ST_FILL/HOLD  : packer FSM state encoding
//   - lane_sel_hit(): lane-select helper used by the assembly registers
// -----------------------------------------------------------------------------
package stream_vect_packer_pkg;

   // FSM encoding: FILL accepts beats, HOLD parks a finished vector in the
   // assembly register while the output register is still occupied.
   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   // Lane counter width; at least one bit so NLANES=1 still has a counter.
   function automatic int lane_cntw(input int nlanes);
      return (nlanes > 1) ? $clog2(nlanes) : 1;
   endfunction

   // True when the currently selected lane is lane_idx.
   function automatic logic lane_sel_hit(input int unsigned lane_sel,
                                         input int unsigned lane_idx);
      return (lane_sel == lane_idx);
   endfunction

endpackage

// File: rtl/stream_vect_lane_asm.sv
// -----------------------------------------------------------------------------
// stream_vect_lane_asm
// One stream's assembly register. A write puts word_in into lane lane_sel;
// a write to lane 0 also clears every other lane so a short (ilast) vector
// carries zeros in the lanes it never reached.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   wr_en        : write word_in this cycle
//   lane_sel     : destination lane
//   word_in      : scalar word
//   vec_d        : assembly contents including this cycle's write
//   vec_q        : registered assembly contents
// -----------------------------------------------------------------------------
module stream_vect_lane_asm
   import stream_vect_packer_pkg::*;
#(
   parameter int WORDW  = 32,
   parameter int NLANES = 2,
   parameter int LCW    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [LCW-1:0]          lane_sel,
   input  logic [WORDW-1:0]        word_in,
   output logic [WORDW*NLANES-1:0] vec_d,
   output logic [WORDW*NLANES-1:0] vec_q
);

   generate
      for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
         logic [WORDW-1:0] lane_q;
         logic [WORDW-1:0] lane_d;

         always_comb begin
            lane_d = lane_q;
            if (wr_en) begin
               if (lane_sel_hit(32'(lane_sel), gi)) begin
                  lane_d = word_in;
               end else if (lane_sel == '0) begin
                  lane_d = '0;
               end
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               lane_q <= '0;
            end else begin
               lane_q <= lane_d;
            end
         end

         assign vec_d[gi*WORDW +: WORDW] = lane_d;
         assign vec_q[gi*WORDW +: WORDW] = lane_q;
      end
   endgenerate

endmodule

// File: rtl/stream_vect_packer.sv
// -----------------------------------------------------------------------------
// stream_vect_packer
// Packs NLANES consecutive scalar beats of two streams (vin0, vin1) into
// STREAMW-wide vectors, lane k at [(k+1)*WORDW-1 : k*WORDW]. Assembly
// register plus output register, so packing continues while the consumer
// stalls for one vector.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   ivalid/iready/ilast   : input beat handshake, ilast closes a vector early
//   vin0_word, vin1_word  : scalar input words
//   ovalid/oready/olast   : packed vector handshake, olast marks final vector
//   vin0_stream_load      : packed stream-0 vector
//   vin1_stream_load      : packed stream-1 vector
// -----------------------------------------------------------------------------
module stream_vect_packer
   import stream_vect_packer_pkg::*;
#(
   parameter int WORDW   = 32,
   parameter int NLANES  = 2,
   parameter int STREAMW = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ivalid,
   output logic               iready,
   input  logic               ilast,
   input  logic [WORDW-1:0]   vin0_word,
   input  logic [WORDW-1:0]   vin1_word,
   output logic               ovalid,
   input  logic               oready,
   output logic               olast,
   output logic [STREAMW-1:0] vin0_stream_load,
   output logic [STREAMW-1:0] vin1_stream_load
);

   localparam int LANE_CNTW = lane_cntw(NLANES);

   generate
      if (STREAMW != WORDW * NLANES) begin : g_bad_width
         $error("stream_vect_packer: STREAMW must equal WORDW*NLANES");
      end
   endgenerate

   logic [0:0]           state_q, state_d;
   logic [LANE_CNTW-1:0] lane_cnt_q, lane_cnt_d;
   logic                 asm_last_q, asm_last_d;
   logic                 iready_q, iready_d;
   logic                 ovalid_q, ovalid_d;
   logic                 olast_q, olast_d;
   logic [STREAMW-1:0]   out0_q, out0_d;
   logic [STREAMW-1:0]   out1_q, out1_d;

   logic [STREAMW-1:0]   asm0_d, asm0_q;
   logic [STREAMW-1:0]   asm1_d, asm1_q;

   logic accept;
   logic out_free;
   logic vec_done;

   // iready is registered so it stays low during reset and rises on the
   // first edge after release; it always mirrors "state is FILL".
   assign accept   = ivalid & iready_q;
   assign out_free = !ovalid_q | oready;
   assign vec_done = accept & ((lane_cnt_q == LANE_CNTW'(NLANES - 1)) | ilast);

   stream_vect_lane_asm #(
      .WORDW  (WORDW),
      .NLANES (NLANES),
      .LCW    (LANE_CNTW)
   ) u_asm0 (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (accept),
      .lane_sel (lane_cnt_q),
      .word_in  (vin0_word),
      .vec_d    (asm0_d),
      .vec_q    (asm0_q)
   );

   stream_vect_lane_asm #(
      .WORDW  (WORDW),
      .NLANES (NLANES),
      .LCW    (LANE_CNTW)
   ) u_asm1 (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (accept),
      .lane_sel (lane_cnt_q),
      .word_in  (vin1_word),
      .vec_d    (asm1_d),
      .vec_q    (asm1_q)
   );

   always_comb begin
      state_d    = state_q;
      lane_cnt_d = lane_cnt_q;
      asm_last_d = asm_last_q;
      ovalid_d   = ovalid_q;
      olast_d    = olast_q;
      out0_d     = out0_q;
      out1_d     = out1_q;

      // A transfer empties the output register unless a new vector lands
      // in it below; data and olast are left untouched.
      if (ovalid_q && oready) begin
         ovalid_d = 1'b0;
      end

      if (state_q == ST_FILL) begin
         if (accept) begin
            if (vec_done) begin
               if (out_free) begin
                  // Bypass straight into the output register, no bubble.
                  out0_d     = asm0_d;
                  out1_d     = asm1_d;
                  ovalid_d   = 1'b1;
                  olast_d    = ilast;
                  lane_cnt_d = '0;
               end else begin
                  asm_last_d = ilast;
                  state_d    = ST_HOLD;
               end
            end else begin
               lane_cnt_d = lane_cnt_q + LANE_CNTW'(1);
            end
         end
      end else if (oready) begin
         // HOLD implies ovalid=1, so oready alone is a transfer here.
         out0_d     = asm0_q;
         out1_d     = asm1_q;
         ovalid_d   = 1'b1;
         olast_d    = asm_last_q;
         lane_cnt_d = '0;
         state_d    = ST_FILL;
      end

      iready_d = (state_d == ST_FILL);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_FILL;
         lane_cnt_q <= '0;
         asm_last_q <= 1'b0;
         iready_q   <= 1'b0;
         ovalid_q   <= 1'b0;
         olast_q    <= 1'b0;
         out0_q     <= '0;
         out1_q     <= '0;
      end else begin
         state_q    <= state_d;
         lane_cnt_q <= lane_cnt_d;
         asm_last_q <= asm_last_d;
         iready_q   <= iready_d;
         ovalid_q   <= ovalid_d;
         olast_q    <= olast_d;
         out0_q     <= out0_d;
         out1_q     <= out1_d;
      end
   end

   assign iready           = iready_q;
   assign ovalid           = ovalid_q;
   assign olast            = olast_q;
   assign vin0_stream_load = out0_q;
   assign vin1_stream_load = out1_q;

endmodule

// File: tb/tb_stream_vect_packer.sv
// -----------------------------------------------------------------------------
// tb_stream_vect_packer
// Directed bench for stream_vect_packer (WORDW=32, NLANES=2, STREAMW=64).
// Inputs change 1 ns after a rising edge; outputs are compared at that point.
// -----------------------------------------------------------------------------
module tb_stream_vect_packer;

   logic        clk;
   logic        rst;
   logic        ivalid;
   logic        iready;
   logic        ilast;
   logic [31:0] vin0_word;
   logic [31:0] vin1_word;
   logic        ovalid;
   logic        oready;
   logic        olast;
   logic [63:0] vin0_stream_load;
   logic [63:0] vin1_stream_load;

   int checks;
   int errors;

   stream_vect_packer #(
      .WORDW   (32),
      .NLANES  (2),
      .STREAMW (64)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .ivalid           (ivalid),
      .iready           (iready),
      .ilast            (ilast),
      .vin0_word        (vin0_word),
      .vin1_word        (vin1_word),
      .ovalid           (ovalid),
      .oready           (oready),
      .olast            (olast),
      .vin0_stream_load (vin0_stream_load),
      .vin1_stream_load (vin1_stream_load)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %-16s observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] w0, input logic [31:0] w1, input logic last);
      ivalid    = 1'b1;
      vin0_word = w0;
      vin1_word = w1;
      ilast     = last;
   endtask

   task automatic idle();
      ivalid = 1'b0;
      ilast  = 1'b0;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      ivalid    = 1'b0;
      ilast     = 1'b0;
      oready    = 1'b0;
      vin0_word = '0;
      vin1_word = '0;

      // ---------------- reset ----------------
      #1 rst = 1'b0;
      tick();
      tick();
      chk("rst_ovalid", 64'(ovalid), 64'h0);
      chk("rst_olast",  64'(olast),  64'h0);
      chk("rst_iready", 64'(iready), 64'h0);
      chk("rst_vin0",   vin0_stream_load, 64'h0);
      chk("rst_vin1",   vin1_stream_load, 64'h0);
      rst = 1'b1;
      tick();
      chk("rel_iready", 64'(iready), 64'h1);

      // ---------------- basic two-beat vector ----------------
      oready = 1'b1;
      beat(32'h11, 32'hA1, 1'b0);
      tick();
      chk("b1_ovalid", 64'(ovalid), 64'h0);
      beat(32'h22, 32'hA2, 1'b0);
      tick();
      chk("b2_ovalid", 64'(ovalid), 64'h1);
      chk("b2_vin0",   vin0_stream_load, 64'h00000022_00000011);
      chk("b2_vin1",   vin1_stream_load, 64'h000000A2_000000A1);
      chk("b2_olast",  64'(olast), 64'h0);
      idle();
      tick();
      chk("b3_ovalid", 64'(ovalid), 64'h0);
      chk("b3_vin0_hold", vin0_stream_load, 64'h00000022_00000011);

      // ---------------- 8 continuous beats ----------------
      for (int i = 0; i < 8; i++) begin
         beat(32'h100 + 32'(i), 32'h200 + 32'(i), 1'b0);
         tick();
         chk("cont_iready", 64'(iready), 64'h1);
         chk("cont_ovalid", 64'(ovalid), 64'(i % 2));
         if (i % 2 == 1) begin
            chk("cont_vin0", vin0_stream_load,
                {32'h100 + 32'(i), 32'h100 + 32'(i - 1)});
            chk("cont_vin1", vin1_stream_load,
                {32'h200 + 32'(i), 32'h200 + 32'(i - 1)});
         end
      end
      idle();
      tick();

      // ---------------- backpressure ----------------
      oready = 1'b0;
      beat(32'h300, 32'h400, 1'b0);
      tick();
      beat(32'h301, 32'h401, 1'b0);
      tick();
      chk("bp_v1_ovalid", 64'(ovalid), 64'h1);
      chk("bp_v1_vin0",   vin0_stream_load, 64'h00000301_00000300);
      beat(32'h302, 32'h402, 1'b0);
      tick();
      chk("bp_iready2", 64'(iready), 64'h1);
      beat(32'h303, 32'h403, 1'b0);
      tick();
      chk("bp_hold_iready", 64'(iready), 64'h0);
      beat(32'h304, 32'h404, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_stall_iready", 64'(iready), 64'h0);
         chk("bp_stall_ovalid", 64'(ovalid), 64'h1);
         chk("bp_stall_vin0",   vin0_stream_load, 64'h00000301_00000300);
         chk("bp_stall_vin1",   vin1_stream_load, 64'h00000401_00000400);
      end
      oready = 1'b1;
      tick();
      chk("bp_drain_ovalid", 64'(ovalid), 64'h1);
      chk("bp_drain_vin0",   vin0_stream_load, 64'h00000303_00000302);
      chk("bp_drain_vin1",   vin1_stream_load, 64'h00000403_00000402);
      chk("bp_drain_iready", 64'(iready), 64'h1);
      tick();
      chk("bp_b4_ovalid", 64'(ovalid), 64'h0);
      beat(32'h305, 32'h405, 1'b0);
      tick();
      chk("bp_v3_ovalid", 64'(ovalid), 64'h1);
      chk("bp_v3_vin0",   vin0_stream_load, 64'h00000305_00000304);
      chk("bp_v3_vin1",   vin1_stream_load, 64'h00000405_00000404);
      idle();
      tick();
      chk("bp_end_ovalid", 64'(ovalid), 64'h0);

      // ---------------- single-beat ilast ----------------
      beat(32'h33, 32'hB3, 1'b1);
      tick();
      chk("p1_ovalid", 64'(ovalid), 64'h1);
      chk("p1_vin0",   vin0_stream_load, 64'h00000000_00000033);
      chk("p1_vin1",   vin1_stream_load, 64'h00000000_000000B3);
      chk("p1_olast",  64'(olast), 64'h1);
      idle();
      tick();

      // ---------------- ilast on last lane, then fresh vector ----------------
      beat(32'h66, 32'hD6, 1'b0);
      tick();
      beat(32'h77, 32'hD7, 1'b1);
      tick();
      chk("l2_vin0",  vin0_stream_load, 64'h00000077_00000066);
      chk("l2_vin1",  vin1_stream_load, 64'h000000D7_000000D6);
      chk("l2_olast", 64'(olast), 64'h1);
      beat(32'h88, 32'hE8, 1'b0);
      tick();
      chk("l3_ovalid", 64'(ovalid), 64'h0);
      beat(32'h99, 32'hE9, 1'b0);
      tick();
      chk("l3_vin0",  vin0_stream_load, 64'h00000099_00000088);
      chk("l3_vin1",  vin1_stream_load, 64'h000000E9_000000E8);
      chk("l3_olast", 64'(olast), 64'h0);
      idle();
      tick();

      // ---------------- reset mid-operation ----------------
      oready = 1'b0;
      beat(32'hF0, 32'hF1, 1'b0);
      tick();
      beat(32'hF2, 32'hF3, 1'b0);
      tick();
      beat(32'hAA, 32'hBA, 1'b0);
      tick();
      chk("mr_pend_ovalid", 64'(ovalid), 64'h1);
      idle();
      #2 rst = 1'b0;
      #1;
      chk("mr_ovalid", 64'(ovalid), 64'h0);
      chk("mr_vin0",   vin0_stream_load, 64'h0);
      chk("mr_olast",  64'(olast), 64'h0);
      tick();
      rst    = 1'b1;
      oready = 1'b1;
      tick();
      chk("mr_iready", 64'(iready), 64'h1);
      chk("mr_idle_ovalid", 64'(ovalid), 64'h0);
      beat(32'h44, 32'hC4, 1'b0);
      tick();
      beat(32'h55, 32'hC5, 1'b0);
      tick();
      chk("mr_v_ovalid", 64'(ovalid), 64'h1);
      chk("mr_v_vin0",   vin0_stream_load, 64'h00000055_00000044);
      chk("mr_v_vin1",   vin1_stream_load, 64'h000000C5_000000C4);
      chk("mr_v_olast",  64'(olast), 64'h0);
      idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stream_vect_packer.md
Name: stream_vect_packer

Overview:
- Upstream neighbour of the vectorised kernel top (lanes s0..sN-1 at [WORDW-1:0], [2*WORDW-1:WORDW], ...).
- Takes one scalar word per beat on each of two input streams, vin0 and vin1. It packs NLANES consecutive beats into one STREAMW-wide vector per stream.
- Presents the packed vectors with the valid/ready handshake the kernel top consumes.
- Double-buffered (assembly register plus output register), so packing continues while the kernel stalls.

Parameters:
- WORDW, 32, width of one scalar word / one lane.
- NLANES, 2, lanes per vector (>=1).
- STREAMW, 64, output vector width; must equal WORDW*NLANES (elaboration-time check).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- ivalid  input  1  input beat valid.
- iready  output  1  packer can accept a beat.
- ilast  input  1  final beat of the stream; closes a partial vector.
- vin0_word  input  WORDW  scalar word, stream 0.
- vin1_word  input  WORDW  scalar word, stream 1.
- ovalid  output  1  packed vector valid.
- oready  input  1  downstream kernel top accepts the vector.
- olast  output  1  vector contains the stream's final beat.
- vin0_stream_load  output  STREAMW  packed stream-0 vector.
- vin1_stream_load  output  STREAMW  packed stream-1 vector.

Behaviour:
- Reset (rst=0, asynchronous): lane_cnt=0, asm_full=0, asm regs=0, ovalid=0, olast=0, both output vectors=0, FSM=FILL. iready is 1 one cycle after release.
- Handshakes:
  - Input accept = ivalid & iready.
  - Output transfer = ovalid & oready.
  - out_free = !ovalid | oready.
- FSM has two states.
  - FILL: iready=1.
  - HOLD: asm_full=1, iready=0.
- Accepted beat in FILL:
  - Writes vin0_word/vin1_word into lane lane_cnt of asm0/asm1. Lane k occupies bits [(k+1)*WORDW-1 : k*WORDW].
  - When lane_cnt==0, all other lanes are cleared in the same cycle.
- Vector complete when the accepted beat has lane_cnt==NLANES-1 or ilast=1.
  - If out_free: next cycle the output regs hold the vector, ovalid=1, olast=ilast. lane_cnt->0 and FSM stays FILL.
  - Else: vector stays in asm, asm_last=ilast, FSM->HOLD, lane_cnt unchanged.
- Incomplete beat: lane_cnt increments and stays in FILL.
- HOLD: on an output transfer, asm is copied to the output regs and ovalid stays 1. lane_cnt->0, FSM->FILL. iready is 1 the following cycle.
- Output transfer with no new vector ready: ovalid->0 next cycle; data regs hold their values.
- While ovalid=1 and oready=0: vin*_stream_load, olast and ovalid are held stable.
- Latency: last beat of a vector accepted in cycle t -> ovalid in t+1 (when out_free).
- Throughput: one beat/cycle sustained while oready=1; no bubbles at vector boundaries.
- Partial vector (ilast before lane NLANES-1): unwritten lanes are output as 0, olast=1.
- ilast on lane NLANES-1: ordinary full vector with olast=1.
- Next beat after ilast starts a fresh vector at lane 0.
- ivalid=0: no state change. Inputs are ignored when iready=0.
- Reset mid-operation: partial assembly and pending output are discarded, no output beat is produced. Post-reset behaviour is identical to power-up.
- NLANES=1: every beat is complete; the block behaves as a 2-entry skid buffer.

Decomposition:
- Shared package holds:
  - LANE_CNTW = max(1, clog2(NLANES)).
  - The FSM state encoding (FILL=1'b0, HOLD=1'b1).
  - A lane-select helper function.
- One sub-module is natural: stream_vect_lane_asm. It is one stream's assembly register, with lane write, lane clear and complete output, and is instantiated twice (vin0, vin1). The FSM, counters and output regs stay in the top.

Test Plan:
- Reset, then oready=1; beats (vin0,vin1)=(0x11,0xA1),(0x22,0xA2) -> one cycle after beat 2: ovalid=1, vin0=0x00000022_00000011, vin1=0x000000A2_000000A1, olast=0.
- Continuous 8 beats, oready=1 -> 4 vectors on consecutive alternate cycles; iready never 0; lane order preserved.
- oready=0 held, 6 beats offered:
  - Vectors 1 and 2 are absorbed, then iready=0 and ovalid held with data stable.
  - oready=1 -> vectors out in order; iready returns 1 a cycle after the HOLD drain.
- Single beat (0x33,0xB3) with ilast=1 -> vin0=0x00000000_00000033, vin1=0x00000000_000000B3, olast=1.
- Two beats, second with ilast=1 -> full vector, olast=1; next beat lands in lane 0.
- After one lane is written, assert rst=0 mid-vector -> ovalid=0 immediately. After release, beats (0x44,0xC4),(0x55,0xC5) -> vin0=0x00000055_00000044; the pre-reset word is absent.
